// File: rtl/led_mode_sched.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sched
// Purpose  : Steps one of four LED pattern engines and sequences between
//            modes. LED_SCHED_AUTO_EN adds the auto port and timed advance.
// Revision : 1.0
// ============================================================================
module led_mode_sched #(
   parameter int TICK_DIV       = 4,
   parameter int STEPS_PER_MODE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       next,
   input  logic       hold,
`ifdef LED_SCHED_AUTO_EN
   input  logic       auto,
`endif
   output logic [3:0] en,
   output logic [3:0] mode_rst,
   output logic [1:0] sel
);

   localparam int c_PRE_W  = $clog2(TICK_DIV);
   localparam int c_STEP_W = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
   localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(TICK_DIV - 1);
   localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEPS_PER_MODE - 1);

   localparam logic [0:0] c_ST_RUN    = 1'b0;
   localparam logic [0:0] c_ST_SWITCH = 1'b1;

   logic [0:0]          r_state;
   logic [c_PRE_W-1:0]  r_pre_cnt;
   logic [c_STEP_W-1:0] r_step_cnt;
   logic [3:0]          r_en;
   logic [3:0]          r_mode_rst;
   logic [1:0]          r_sel;

   logic       w_step;
   logic       w_wrap;
   logic       w_step_last;
   logic       w_expire;
   logic       w_advance;
   logic [1:0] w_sel_nxt;

   function automatic logic [3:0] f_onehot(input logic [1:0] i_idx);
      return 4'b0001 << i_idx;
   endfunction

   assign w_step      = (r_state == c_ST_RUN) && !hold;
   assign w_wrap      = w_step && (r_pre_cnt == c_PRE_LAST);
   assign w_step_last = (r_step_cnt == c_STEP_LAST);
   assign w_sel_nxt   = r_sel + 2'd1;

`ifdef LED_SCHED_AUTO_EN
   assign w_expire = auto && w_wrap && w_step_last;
`else
   assign w_expire = 1'b0;
`endif

   // A next pulse coinciding with expiry still produces a single advance.
   assign w_advance = (next && w_step) || w_expire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= c_ST_RUN;
         r_pre_cnt  <= '0;
         r_step_cnt <= '0;
         r_en       <= 4'b0000;
         r_mode_rst <= 4'b0000;
         r_sel      <= 2'd0;
      end else begin
         r_en       <= 4'b0000;
         r_mode_rst <= 4'b0000;
         case (r_state)
            c_ST_RUN: begin
               if (w_step) begin
                  if (w_wrap) begin
                     r_pre_cnt <= '0;
                     r_en      <= f_onehot(r_sel);
                     if (!w_step_last) begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                     end
                  end else begin
                     r_pre_cnt <= r_pre_cnt + 1'b1;
                  end
               end
               if (w_advance) begin
                  r_state <= c_ST_SWITCH;
               end
            end
            c_ST_SWITCH: begin
               r_sel      <= w_sel_nxt;
               r_mode_rst <= f_onehot(w_sel_nxt);
               r_pre_cnt  <= '0;
               r_step_cnt <= '0;
               r_state    <= c_ST_RUN;
            end
            default: begin
               r_state <= c_ST_RUN;
            end
         endcase
      end
   end

   assign en       = r_en;
   assign mode_rst = r_mode_rst;
   assign sel      = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_sched
// Purpose  : Directed scoreboard bench for led_mode_sched (auto section only
//            with LED_SCHED_AUTO_EN).
// Revision : 1.0
// ============================================================================
module tb_led_mode_sched;

   localparam int c_TDIV = 4;

   typedef struct {
      string      tag;
      logic [9:0] v;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       next;
   logic       hold;
   logic [3:0] en;
   logic [3:0] mode_rst;
   logic [1:0] sel;
   logic [9:0] obs;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   led_mode_sched #(.TICK_DIV(c_TDIV), .STEPS_PER_MODE(16)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .next     (next),
      .hold     (hold),
`ifdef LED_SCHED_AUTO_EN
      .auto     (1'b0),
`endif
      .en       (en),
      .mode_rst (mode_rst),
      .sel      (sel)
   );

`ifdef LED_SCHED_AUTO_EN
   logic       use_auto = 1'b0;
   logic       a_reset;
   logic [3:0] a_en;
   logic [3:0] a_rst;
   logic [1:0] a_sel;

   led_mode_sched #(.TICK_DIV(2), .STEPS_PER_MODE(3)) u_auto (
      .clk      (clk),
      .reset    (a_reset),
      .next     (next),
      .hold     (hold),
      .auto     (1'b1),
      .en       (a_en),
      .mode_rst (a_rst),
      .sel      (a_sel)
   );
`endif

   always_comb begin
      obs = {en, mode_rst, sel};
`ifdef LED_SCHED_AUTO_EN
      if (use_auto) obs = {a_en, a_rst, a_sel};
`endif
   end

   function automatic logic [3:0] oh(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   task automatic push(input string tag, input logic [3:0] e_en,
                       input logic [3:0] e_rst, input logic [1:0] e_sel);
      exp_t x;
      x.tag = tag;
      x.v   = {e_en, e_rst, e_sel};
      q.push_back(x);
   endtask

   task automatic check_pop();
      exp_t x;
      x = q.pop_front();
      checks++;
      assert (obs === x.v) else begin
         errors++;
         $error("FAIL %s: observed en/rst/sel=%b expected %b", x.tag, obs, x.v);
      end
   endtask

   // Drive inputs for one edge, queue the expected post-edge outputs, compare.
   task automatic cyc(input logic n, input logic h, input logic [3:0] e_en,
                      input logic [3:0] e_rst, input logic [1:0] e_sel,
                      input string tag);
      next = n;
      hold = h;
      push(tag, e_en, e_rst, e_sel);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic run_mode(input logic [1:0] s, input int n, input bit do_next);
      for (int off = 1; off <= n; off++) begin
         cyc(do_next && (off == n), 1'b0,
             ((off % c_TDIV) == 0) ? oh(s) : 4'b0000, 4'b0000, s, "run_step");
      end
      if (do_next) cyc(1'b0, 1'b0, 4'b0000, oh(s + 2'd1), s + 2'd1, "mode_entry");
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      push("reset_async", 4'b0000, 4'b0000, 2'd0);
      check_pop();
      @(negedge clk);
      reset = 1'b0;
   endtask

`ifdef LED_SCHED_AUTO_EN
   // Two-clock steps, three steps per mode, then one SWITCH cycle.
   task automatic auto_mode(input logic [1:0] s, input bit next_at_expiry);
      for (int off = 1; off <= 6; off++) begin
         cyc(next_at_expiry && (off == 6), 1'b0,
             ((off % 2) == 0) ? oh(s) : 4'b0000, 4'b0000, s, "auto_step");
      end
      cyc(1'b0, 1'b0, 4'b0000, oh(s + 2'd1), s + 2'd1, "auto_entry");
   endtask
`endif

   initial begin
      reset = 1'b1;
      next  = 1'b0;
      hold  = 1'b0;
`ifdef LED_SCHED_AUTO_EN
      a_reset = 1'b1;
`endif
      #2;
      push("reset_state", 4'b0000, 4'b0000, 2'd0);
      check_pop();
      @(negedge clk);
      reset = 1'b0;

      // Idle cadence: en[0] after edges 4, 8, 12.
      run_mode(2'd0, 12, 1'b0);

      // next at edge 6 -> sel=1 after 7, first en[1] after 11.
      do_reset();
      run_mode(2'd0, 6, 1'b1);
      run_mode(2'd1, 9, 1'b1);
      run_mode(2'd2, 9, 1'b1);
      run_mode(2'd3, 9, 1'b1);
      run_mode(2'd0, 9, 1'b1);

      // Hold starting on what would be a wrap edge, next pulse ignored inside.
      for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, "pre_hold");
      for (int i = 1; i <= 20; i++) cyc(i == 10, 1'b1, 4'b0000, 4'b0000, 2'd1, "hold");
      cyc(1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, "hold_release_wrap");
      for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, "post_hold");

      // next on a wrap edge, then reset while in SWITCH.
      cyc(1'b1, 1'b0, 4'b0010, 4'b0000, 2'd1, "next_on_wrap");
      next = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      push("reset_in_switch", 4'b0000, 4'b0000, 2'd0);
      check_pop();
      @(negedge clk);
      reset = 1'b0;
      run_mode(2'd0, 8, 1'b0);

`ifdef LED_SCHED_AUTO_EN
      @(negedge clk);
      use_auto = 1'b1;
      a_reset  = 1'b0;
      auto_mode(2'd0, 1'b0);
      auto_mode(2'd1, 1'b1);
      auto_mode(2'd2, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
